// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state encodings shared by the alu_seq slice
package alu_pkg;
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_SUB   = 4'h5;
  localparam logic [3:0] OP_SHL   = 4'h6;
  localparam logic [3:0] OP_SHR   = 4'h7;
  localparam logic [3:0] OP_ASR   = 4'h8;
  localparam logic [3:0] OP_MUL   = 4'h9;
  localparam logic [3:0] OP_ADC   = 4'hA;
  localparam logic [3:0] OP_PASSA = 4'hB;
  localparam logic [3:0] OP_CMP   = 4'hC;
  typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle between the datapath and alu_seq
interface alu_seq_if #(parameter int WIDTH = 16, parameter int OPW = 4);
  logic             Enable;
  logic [OPW-1:0]   Opcode;
  logic [WIDTH-1:0] Data_A;
  logic [WIDTH-1:0] Data_B;
  logic [WIDTH-1:0] Results;
  logic             CF;
  logic             ZF;
  logic             NF;
  logic             VF;
  logic             Busy;
  logic             Done;
  logic             Err;
  modport master (output Enable, Opcode, Data_A, Data_B,
                  input Results, CF, ZF, NF, VF, Busy, Done, Err);
  modport slave (input Enable, Opcode, Data_A, Data_B,
                 output Results, CF, ZF, NF, VF, Busy, Done, Err);
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add multiplier, one partial product per cycle, WIDTH steps
module alu_mul_seq #(parameter int WIDTH = 16) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [2*WIDTH-1:0] mcand, acc;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;
  // product includes the step in progress so the last step can be written back directly
  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = busy && count == CW'(1);
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      busy   <= 1'b0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (start && !busy) begin
      busy   <= 1'b1;
      mcand  <= {{WIDTH{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
      count  <= CW'(WIDTH);
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CW'(1);
      busy   <= !done;
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with NZCV flags, stored-carry ADC and sequential multiply
module alu_seq import alu_pkg::*; #(parameter int WIDTH = 16, parameter int OPW = 4) (
  input logic      CLK,
  input logic      RST,
  alu_seq_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;
  state_t             state, state_n;
  logic               accept, fire, mul_start, mul_busy, mul_done;
  logic               legal, upd_r, cf_n, vf_n;
  logic [WIDTH-1:0]   a, b, res_n;
  logic [WIDTH:0]     sum, dif;
  logic [2*WIDTH-1:0] prod, shl, shr, asr;
  logic [SW-1:0]      sh;
  assign a   = bus.Data_A;
  assign b   = bus.Data_B;
  assign sh  = b[SW-1:0];
  assign sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, bus.Opcode == OP_ADC && bus.CF};
  assign dif = {1'b0, a} - {1'b0, b};
  // shifts run in a double-width window so the last bit shifted out lands next to the result
  assign shl = {{WIDTH{1'b0}}, a} << sh;
  assign shr = {a, {WIDTH{1'b0}}} >> sh;
  assign asr = $signed({a, {WIDTH{1'b0}}}) >>> sh;
  always_comb begin
    res_n = '0;
    cf_n  = 1'b0;
    vf_n  = 1'b0;
    upd_r = 1'b1;
    legal = 1'b1;
    case (bus.Opcode)
      OP_ADD, OP_ADC: begin
        res_n = sum[M:0];
        cf_n  = sum[WIDTH];
        vf_n  = a[M] == b[M] && sum[M] != a[M];
      end
      OP_SUB, OP_CMP: begin
        res_n = dif[M:0];
        cf_n  = dif[WIDTH];
        vf_n  = a[M] != b[M] && dif[M] != a[M];
        upd_r = bus.Opcode != OP_CMP;
      end
      OP_AND:   res_n = a & b;
      OP_OR:    res_n = a | b;
      OP_XOR:   res_n = a ^ b;
      OP_PASSA: res_n = a;
      OP_SHL: begin
        res_n = shl[M:0];
        cf_n  = shl[WIDTH];
      end
      OP_SHR: begin
        res_n = shr[2*WIDTH-1:WIDTH];
        cf_n  = shr[M];
      end
      OP_ASR: begin
        res_n = asr[2*WIDTH-1:WIDTH];
        cf_n  = asr[M];
      end
      OP_NOP, OP_MUL: upd_r = 1'b0;
      default: begin
        legal = 1'b0;
        upd_r = 1'b0;
      end
    endcase
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= ST_IDLE;
    else      state <= state_n;
  always_comb
    state_n = state == ST_IDLE ? (bus.Enable && bus.Opcode == OP_MUL ? ST_MUL : ST_IDLE)
                               : (mul_done ? ST_IDLE : ST_MUL);
  always_comb begin
    accept    = state == ST_IDLE && bus.Enable;
    mul_start = accept && bus.Opcode == OP_MUL;
    fire      = accept && bus.Opcode != OP_NOP && bus.Opcode != OP_MUL;
    bus.Busy  = state == ST_MUL && mul_busy;
  end
  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .CLK(CLK), .RST(RST), .start(mul_start), .a(a), .b(b),
    .busy(mul_busy), .done(mul_done), .product(prod)
  );
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      bus.Results <= '0;
      bus.CF      <= 1'b0;
      bus.ZF      <= 1'b0;
      bus.NF      <= 1'b0;
      bus.VF      <= 1'b0;
      bus.Done    <= 1'b0;
      bus.Err     <= 1'b0;
    end else begin
      bus.Done <= fire || mul_done;
      if (accept) bus.Err <= !legal;
      if (mul_done) begin
        bus.Results <= prod[M:0];
        bus.CF      <= |prod[2*WIDTH-1:WIDTH];
        bus.ZF      <= prod[M:0] == '0;
        bus.NF      <= prod[M];
        bus.VF      <= 1'b0;
      end else if (fire && legal) begin
        if (upd_r) bus.Results <= res_n;
        bus.CF <= cf_n;
        bus.ZF <= res_n == '0;
        bus.NF <= res_n[M];
        bus.VF <= vf_n;
      end
    end
endmodule
